decode_stage: RTL and testbench

- Registered RV32I decode pipeline stage between fetch and register-read/execute.
- Decodes all base formats (R/I/S/B/U/J) and generates sign-extended immediates.
- Zeroes unused register indices so downstream hazard logic sees no false dependencies; flags illegal encodings.
- Valid/ready handshakes on both sides, optional skid buffer for registered back-pressure, and a flush input for branch redirects.

---
 rtl/decode_stage.sv | 125 ++++++++++++
 tb/tb_decode_stage.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// decode_stage: registered RV32I decode stage with valid/ready handshakes, optional skid buffer and flush
module decode_stage #(
  parameter int DWIDTH  = 32,
  parameter int AWIDTH  = 32,
  parameter int SKID_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DWIDTH-1:0] insn_i,
  input  logic [AWIDTH-1:0] pc_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [AWIDTH-1:0] pc_o,
  output logic [DWIDTH-1:0] insn_o,
  output logic [6:0]        opcode_o,
  output logic [4:0]        rd_o,
  output logic [4:0]        rs1_o,
  output logic [4:0]        rs2_o,
  output logic [2:0]        funct3_o,
  output logic [6:0]        funct7_o,
  output logic [4:0]        shamt_o,
  output logic [DWIDTH-1:0] imm_o,
  output logic              illegal_o
);
  typedef struct packed {
    logic [AWIDTH-1:0] pc;
    logic [DWIDTH-1:0] insn;
    logic [6:0]        opcode;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [4:0]        shamt;
    logic [DWIDTH-1:0] imm;
    logic              illegal;
  } bundle_t;
  bundle_t dec, out_d, out_q, skid_d, skid_q;
  logic out_valid_d, out_valid_q, skid_valid_d, skid_valid_q, in_fire, out_fire;
  logic [6:0] op, f7;
  logic [2:0] f3;
  logic is_i, is_s, is_b, is_u, is_j, is_op, is_misc, is_shift, f7_ok, bad;
  always_comb begin
    op       = insn_i[6:0];
    f3       = insn_i[14:12];
    f7       = insn_i[31:25];
    is_i     = op inside {7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011};
    is_s     = op == 7'b0100011;
    is_b     = op == 7'b1100011;
    is_u     = op inside {7'b0110111, 7'b0010111};
    is_j     = op == 7'b1101111;
    is_op    = op == 7'b0110011;
    is_misc  = op == 7'b0001111;
    is_shift = op == 7'b0010011 && f3[1:0] == 2'b01;
    f7_ok    = f7 == 7'b0000000 || f7 == 7'b0100000;
    bad      = insn_i[1:0] != 2'b11 || !(is_i || is_s || is_b || is_u || is_j || is_op || is_misc)
            || (is_op && (!f7_ok || (f7[5] && f3 != 3'b000 && f3 != 3'b101)))
            || (is_shift && (!f7_ok || (f3 == 3'b001 && f7[5])));
    dec.pc      = pc_i;
    dec.insn    = insn_i;
    dec.opcode  = op;
    dec.funct3  = f3;
    dec.funct7  = (is_op || is_shift) ? f7 : 7'd0;
    dec.shamt   = insn_i[24:20];
    dec.illegal = bad;
    dec.rd      = (bad || is_s || is_b) ? 5'd0 : insn_i[11:7];
    dec.rs1     = (bad || is_u || is_j) ? 5'd0 : insn_i[19:15];
    dec.rs2     = (bad || is_i || is_u || is_j) ? 5'd0 : insn_i[24:20];
    dec.imm     = is_i ? {{20{insn_i[31]}}, insn_i[31:20]}
                : is_s ? {{20{insn_i[31]}}, insn_i[31:25], insn_i[11:7]}
                : is_b ? {{19{insn_i[31]}}, insn_i[31], insn_i[7], insn_i[30:25], insn_i[11:8], 1'b0}
                : is_u ? {insn_i[31:12], 12'd0}
                : is_j ? {{11{insn_i[31]}}, insn_i[31], insn_i[19:12], insn_i[20], insn_i[30:21], 1'b0}
                : '0;
  end
  assign in_ready_o = (SKID_EN != 0) ? !skid_valid_q : (out_ready_i || !out_valid_q);
  assign in_fire    = in_valid_i && in_ready_o;
  assign out_fire   = out_valid_q && out_ready_i;
  // The skid entry is only ever filled while the output register is stalled, so it always drains first.
  always_comb begin
    out_d        = out_q;
    skid_d       = skid_q;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush_i) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (out_fire || !out_valid_q) begin
      out_valid_d  = skid_valid_q || in_fire;
      out_d        = skid_valid_q ? skid_q : in_fire ? dec : out_q;
      skid_valid_d = 1'b0;
    end else if (in_fire) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end
  assign out_valid_o = out_valid_q;
  assign pc_o        = out_q.pc;
  assign insn_o      = out_q.insn;
  assign opcode_o    = out_q.opcode;
  assign rd_o        = out_q.rd;
  assign rs1_o       = out_q.rs1;
  assign rs2_o       = out_q.rs2;
  assign funct3_o    = out_q.funct3;
  assign funct7_o    = out_q.funct7;
  assign shamt_o     = out_q.shamt;
  assign imm_o       = out_q.imm;
  assign illegal_o   = out_q.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed checks of decode_stage with and without the skid buffer
module tb_decode_stage;
  logic clk = 1'b0, rst = 1'b0, flush = 1'b0, iv = 1'b0, ordy = 1'b0;
  logic [31:0] insn = '0, pc = '0;
  logic ir, ov, ill;
  logic [31:0] pc_o, insn_o, imm;
  logic [6:0] opc, f7;
  logic [4:0] rd, rs1, rs2, sh;
  logic [2:0] f3;
  logic iv0 = 1'b0, ordy0 = 1'b0;
  logic [31:0] insn0 = '0, pc0 = '0;
  logic ir0, ov0, ill0;
  logic [31:0] pc_o0, insn_o0, imm0;
  logic [6:0] opc0, f70;
  logic [4:0] rd0, rs10, rs20, sh0;
  logic [2:0] f30;
  int n_cmp = 0, n_err = 0;
  localparam logic [31:0] ADD = 32'h007302B3, SUB = 32'h407302B3, ADDI = 32'hFFF10093;

  always #5 clk = ~clk;

  decode_stage #(.DWIDTH(32), .AWIDTH(32), .SKID_EN(1)) dut (
    .clk(clk), .rst(rst), .flush_i(flush), .in_valid_i(iv), .in_ready_o(ir),
    .insn_i(insn), .pc_i(pc), .out_valid_o(ov), .out_ready_i(ordy), .pc_o(pc_o),
    .insn_o(insn_o), .opcode_o(opc), .rd_o(rd), .rs1_o(rs1), .rs2_o(rs2),
    .funct3_o(f3), .funct7_o(f7), .shamt_o(sh), .imm_o(imm), .illegal_o(ill));

  decode_stage #(.DWIDTH(32), .AWIDTH(32), .SKID_EN(0)) dut0 (
    .clk(clk), .rst(rst), .flush_i(1'b0), .in_valid_i(iv0), .in_ready_o(ir0),
    .insn_i(insn0), .pc_i(pc0), .out_valid_o(ov0), .out_ready_i(ordy0), .pc_o(pc_o0),
    .insn_o(insn_o0), .opcode_o(opc0), .rd_o(rd0), .rs1_o(rs10), .rs2_o(rs20),
    .funct3_o(f30), .funct7_o(f70), .shamt_o(sh0), .imm_o(imm0), .illegal_o(ill0));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [31:0] i, input logic [31:0] p);
    iv = 1'b1; insn = i; pc = p;
    step();
  endtask

  task automatic chk_idx(input string tag, input logic [4:0] erd, input logic [4:0] ers1, input logic [4:0] ers2);
    chk({tag, ".rd"}, 64'(rd), 64'(erd));
    chk({tag, ".rs1"}, 64'(rs1), 64'(ers1));
    chk({tag, ".rs2"}, 64'(rs2), 64'(ers2));
  endtask

  initial begin
    // reset with in_valid held high
    iv = 1'b1; insn = ADD; pc = 32'h50; ordy = 1'b1; iv0 = 1'b1; insn0 = ADD;
    step(); step();
    chk("rst.valid", 64'(ov), 64'd0);
    chk("rst.imm", 64'(imm), 64'd0);
    chk("rst.ready", 64'(ir), 64'd1);
    chk("rst.valid0", 64'(ov0), 64'd0);
    rst = 1'b1; iv = 1'b0; iv0 = 1'b0;
    step();
    chk("rst.nothing_accepted", 64'(ov), 64'd0);
    // ADD then SUB back to back
    feed(ADD, 32'h100);
    chk("add.valid", 64'(ov), 64'd1);
    chk("add.pc", 64'(pc_o), 64'h100);
    chk_idx("add", 5'd5, 5'd6, 5'd7);
    chk("add.f7", 64'(f7), 64'h00);
    chk("add.imm", 64'(imm), 64'd0);
    chk("add.ill", 64'(ill), 64'd0);
    feed(SUB, 32'h104);
    chk("sub.valid", 64'(ov), 64'd1);
    chk("sub.pc", 64'(pc_o), 64'h104);
    chk_idx("sub", 5'd5, 5'd6, 5'd7);
    chk("sub.f7", 64'(f7), 64'h20);
    chk("sub.ill", 64'(ill), 64'd0);
    // immediates
    feed(ADDI, 32'h108);
    chk("addi.imm", 64'(imm), 64'hFFFFFFFF);
    chk_idx("addi", 5'd1, 5'd2, 5'd0);
    chk("addi.f7", 64'(f7), 64'd0);
    feed(32'h00512423, 32'h10C);
    chk("sw.imm", 64'(imm), 64'd8);
    chk_idx("sw", 5'd0, 5'd2, 5'd5);
    feed(32'hFE000EE3, 32'h110);
    chk("beq.imm", 64'(imm), 64'hFFFFFFFC);
    chk("beq.rd", 64'(rd), 64'd0);
    feed(32'h123452B7, 32'h114);
    chk("lui.imm", 64'(imm), 64'h12345000);
    chk_idx("lui", 5'd5, 5'd0, 5'd0);
    feed(32'h008000EF, 32'h118);
    chk("jal.imm", 64'(imm), 64'd8);
    chk_idx("jal", 5'd1, 5'd0, 5'd0);
    iv = 1'b0;
    step();
    chk("idle.valid", 64'(ov), 64'd0);
    // back-pressure with the skid buffer
    ordy = 1'b0;
    feed(ADD, 32'h200);
    chk("bp.a_valid", 64'(ov), 64'd1);
    chk("bp.ready_after_a", 64'(ir), 64'd1);
    feed(SUB, 32'h204);
    chk("bp.ready_after_b", 64'(ir), 64'd0);
    chk("bp.hold_pc", 64'(pc_o), 64'h200);
    feed(ADDI, 32'h208);
    chk("bp.c_refused", 64'(ir), 64'd0);
    chk("bp.hold_pc2", 64'(pc_o), 64'h200);
    chk("bp.hold_insn", 64'(insn_o), 64'(ADD));
    ordy = 1'b1;
    step();
    chk("bp.out_b_pc", 64'(pc_o), 64'h204);
    chk("bp.out_b_insn", 64'(insn_o), 64'(SUB));
    chk("bp.ready_again", 64'(ir), 64'd1);
    step();
    chk("bp.out_c_pc", 64'(pc_o), 64'h208);
    chk("bp.out_c_insn", 64'(insn_o), 64'(ADDI));
    iv = 1'b0;
    step();
    chk("bp.drained", 64'(ov), 64'd0);
    // flush with output and skid both full, plus a same-cycle input
    ordy = 1'b0;
    feed(ADD, 32'h300);
    feed(SUB, 32'h304);
    chk("fl.skid_full", 64'(ir), 64'd0);
    flush = 1'b1; insn = ADDI; pc = 32'h308;
    step();
    flush = 1'b0; iv = 1'b0;
    chk("fl.valid", 64'(ov), 64'd0);
    chk("fl.ready", 64'(ir), 64'd1);
    ordy = 1'b1;
    step();
    chk("fl.no_reappear", 64'(ov), 64'd0);
    // flush dropping an input that would otherwise be accepted
    ordy = 1'b0;
    feed(ADD, 32'h310);
    flush = 1'b1; insn = SUB; pc = 32'h314;
    step();
    flush = 1'b0; iv = 1'b0;
    chk("fl2.valid", 64'(ov), 64'd0);
    ordy = 1'b1;
    step();
    chk("fl2.dropped", 64'(ov), 64'd0);
    // illegal encodings
    feed(32'h00000000, 32'h400);
    chk("ill0.flag", 64'(ill), 64'd1);
    chk("ill0.valid", 64'(ov), 64'd1);
    chk_idx("ill0", 5'd0, 5'd0, 5'd0);
    feed(32'h0000007F, 32'h404);
    chk("ill7f.flag", 64'(ill), 64'd1);
    chk_idx("ill7f", 5'd0, 5'd0, 5'd0);
    feed(32'h027302B3, 32'h408);
    chk("illf7.flag", 64'(ill), 64'd1);
    chk("illf7.valid", 64'(ov), 64'd1);
    chk_idx("illf7", 5'd0, 5'd0, 5'd0);
    feed(32'h40731293, 32'h40C);
    chk("ill_srai_f3.flag", 64'(ill), 64'd1);
    feed(32'h40735293, 32'h410);
    chk("srai.flag", 64'(ill), 64'd0);
    chk("srai.f7", 64'(f7), 64'h20);
    iv = 1'b0;
    step();
    // back-pressure without the skid buffer
    ordy0 = 1'b0; iv0 = 1'b1; insn0 = ADD; pc0 = 32'h500;
    step();
    chk("ns.a_valid", 64'(ov0), 64'd1);
    chk("ns.ready", 64'(ir0), 64'd0);
    insn0 = SUB; pc0 = 32'h504;
    step();
    chk("ns.hold_pc", 64'(pc_o0), 64'h500);
    insn0 = ADDI; pc0 = 32'h508;
    step();
    chk("ns.hold_pc2", 64'(pc_o0), 64'h500);
    ordy0 = 1'b1;
    #1;
    chk("ns.ready_comb", 64'(ir0), 64'd1);
    step();
    chk("ns.out_c_pc", 64'(pc_o0), 64'h508);
    chk("ns.out_c_imm", 64'(imm0), 64'hFFFFFFFF);
    iv0 = 1'b0;
    step();
    chk("ns.drained", 64'(ov0), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
